eth_tx_framer: RTL and testbench
================================

Name: eth_tx_framer

Overview:
Transmit-side MAC framer feeding the GMII transmit interface of the gig_eth_pcs_pma core. It accepts a byte stream (destination MAC through payload) with a valid/ready/last handshake and emits preamble, SFD, the frame bytes, and zero padding to the minimum frame size. It then appends the IEEE 802.3 CRC-32 FCS and enforces the inter-frame gap. The CRC-32 byte step is computed inline each cycle.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 bytes before SFD
MIN_FRAME_LEN, 60, minimum bytes before FCS (padding target, excludes FCS)
IFG_CYCLES, 12, idle cycles after the last FCS byte, tx_en low

Ports:
clock  input  1  byte clock (125 MHz GMII)
reset  input  1  asynchronous, active-high reset
s_data  input  8  frame byte (dest MAC first)
s_valid  input  1  s_data valid
s_last  input  1  marks the final frame byte
s_ready  output  1  byte accepted when s_valid & s_ready
gmii_txd  output  8  GMII transmit data
gmii_tx_en  output  1  GMII transmit enable
gmii_tx_er  output  1  GMII transmit error
underrun  output  1  one-cycle pulse when the frame is aborted
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, CRC register 0xFFFFFFFF, all counters 0.
- All GMII outputs and s_ready are registered. Combinational s_ready is not permitted.
- IDLE: on s_valid=1, go to PREAMBLE without consuming the byte.
- PREAMBLE: drive 0x55 with tx_en=1 for PREAMBLE_LEN cycles, then go to SFD.
- SFD: drive 0xD5 for one cycle. Set the CRC register to 0xFFFFFFFF and byte_count to 0.
- Registered s_ready: s_ready is driven high in the cycle before DATA so that the first DATA cycle accepts a byte.
- Output timing: s_valid seen in IDLE at cycle N gives the first 0x55 at N+1, SFD at N+1+PREAMBLE_LEN, and the first data byte at N+2+PREAMBLE_LEN.
- DATA: each handshake outputs s_data on gmii_txd the next cycle, updates the CRC, and increments byte_count (16-bit, saturating at 0xFFFF).
- s_last accepted: s_ready drops. If byte_count < MIN_FRAME_LEN, go to PAD; otherwise go to FCS.
- Underrun: s_valid=0 while in DATA with s_last not yet seen. Drive tx_en=1, tx_er=1, txd=0x00 for one cycle and pulse underrun. Go to IFG with no FCS sent.
- PAD: drive 0x00 and update the CRC until byte_count == MIN_FRAME_LEN, then go to FCS.
- CRC convention: reflected CRC-32, polynomial 0x04C11DB7, input bit d[0] first. The FCS equals the complemented register.
- FCS: drive 4 bytes, ~crc[7:0], ~crc[15:8], ~crc[23:16], ~crc[31:24], in that order.
- IFG: drive tx_en=0, txd=0x00 for IFG_CYCLES cycles, then go to IDLE. s_ready stays 0 throughout.
- s_valid high during IFG is held off. The next frame's PREAMBLE starts the cycle after IFG completes.
- s_last on the very first byte is legal: a 1-byte frame is padded.
- reset asserted mid-frame: outputs clear immediately, tx_en drops, no FCS, state IDLE.
- busy stays high from PREAMBLE through IFG inclusive.

Optional Feature:
ETH_TX_FRAMER_PAD_EN.
- Defined: PAD state present, frames shorter than MIN_FRAME_LEN are zero-padded as above.
- Undefined: PAD state omitted, DATA goes straight to FCS after s_last regardless of length, and MIN_FRAME_LEN is unused.

Test Plan:
- Macro undefined, 9-byte payload "123456789" (0x31..0x39), s_valid continuous -> 7x0x55, 0xD5, 9 bytes, FCS 0x26 0x39 0xF4 0xCB, tx_en low for 12 cycles.
- Macro defined, same 9 bytes -> 51 bytes 0x00 after payload (60 total), then FCS of the padded frame matching the software reference model, tx_en high for exactly 72 cycles.
- 64-byte frame, s_valid drops at byte 20 -> byte 20 slot is txd=0x00 with tx_er=1, underrun pulses once, no FCS, IFG follows, busy returns 0 after 12 idle cycles.
- Two back-to-back 60-byte frames with s_valid held high -> exactly 12 cycles of tx_en=0 between the last FCS byte and the next 0x55, and no bytes lost.
- reset pulsed during PREAMBLE cycle 3 -> tx_en=0 the same cycle, and the next frame after release starts with a full 7-byte preamble.
- 1-byte frame with s_last on the first byte (macro defined) -> 60 frame bytes plus 4 FCS bytes, and s_ready high for exactly one cycle.

Source files
------------

// File: rtl/eth_tx_framer.sv
// eth_tx_framer
// Transmit-side MAC framer for a GMII transmit interface. Takes a byte stream
// (destination MAC through payload) over valid/ready/last, and puts preamble,
// SFD, the frame, optional zero padding, the CRC-32 FCS and the inter-frame
// gap on the wire. A reflected CRC-32 (poly 0x04C11DB7) is advanced one byte
// per cycle.
//
// Build option: define ETH_TX_FRAMER_PAD_EN to zero-pad short frames up to
// MIN_FRAME_LEN bytes before the FCS. Without it, frames go straight from the
// last data byte to the FCS.
//
// The state register names what is on the wire in the current cycle. Every
// output is a flop, so each cycle's logic decides the byte of the next cycle.
module eth_tx_framer #(
    parameter int PREAMBLE_LEN  = 7,
    parameter int MIN_FRAME_LEN = 60,
    parameter int IFG_CYCLES    = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       underrun,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRE   = 3'd1;
    localparam logic [2:0] ST_SFD   = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
`ifdef ETH_TX_FRAMER_PAD_EN
    localparam logic [2:0] ST_PAD   = 3'd4;
`else
    // Padding target is meaningless without the padding logic.
    localparam int unused_min_frame_len = MIN_FRAME_LEN;
`endif
    localparam logic [2:0] ST_FCS   = 3'd5;
    localparam logic [2:0] ST_ABORT = 3'd6;
    localparam logic [2:0] ST_IFG   = 3'd7;

    localparam logic [7:0]  PRE_LAST     = 8'(PREAMBLE_LEN);
    localparam logic [7:0]  IFG_LAST     = 8'(IFG_CYCLES);
    localparam logic [31:0] CRC_POLY_REV = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] byte_count_q, byte_count_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic        s_ready_q, s_ready_d;
    logic        underrun_q, underrun_d;

    logic [7:0]  crc_byte;
    logic [31:0] crc_stage [9];
    logic [31:0] crc_next;
    logic [15:0] byte_count_inc;
    logic        tail_step;

    // While s_ready is high the CRC eats the accepted byte; otherwise it is a pad byte.
    assign crc_byte     = s_ready_q ? s_data : 8'h00;
    assign crc_stage[0] = crc_q ^ {24'd0, crc_byte};

    // Eight LSB-first shift/xor steps make up one byte of the reflected CRC.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_crc_bit
            assign crc_stage[gi+1] = crc_stage[gi][0] ? ((crc_stage[gi] >> 1) ^ CRC_POLY_REV)
                                                      : (crc_stage[gi] >> 1);
        end
    endgenerate

    assign crc_next       = crc_stage[8];
    assign byte_count_inc = (byte_count_q == 16'hFFFF) ? byte_count_q : byte_count_q + 16'd1;

    // Next-state and next-output decode; outputs default to an idle wire.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        crc_d        = crc_q;
        byte_count_d = byte_count_q;
        txd_d        = 8'h00;
        tx_en_d      = 1'b0;
        tx_er_d      = 1'b0;
        s_ready_d    = 1'b0;
        underrun_d   = 1'b0;
        tail_step    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The waiting byte is not consumed here; it is taken after the SFD.
                if (s_valid) begin
                    state_d = ST_PRE;
                    cnt_d   = 8'd1;
                    txd_d   = 8'h55;
                    tx_en_d = 1'b1;
                end
            end
            ST_PRE: begin
                tx_en_d = 1'b1;
                if (cnt_q == PRE_LAST) begin
                    state_d      = ST_SFD;
                    cnt_d        = 8'd0;
                    txd_d        = 8'hD5;
                    s_ready_d    = 1'b1;
                    crc_d        = CRC_INIT;
                    byte_count_d = 16'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    txd_d = 8'h55;
                end
            end
            ST_SFD, ST_DATA: begin
                if (s_ready_q) begin
                    tx_en_d = 1'b1;
                    if (s_valid) begin
                        state_d      = ST_DATA;
                        txd_d        = s_data;
                        crc_d        = crc_next;
                        byte_count_d = byte_count_inc;
                        s_ready_d    = !s_last;
                    end else begin
                        // Source ran dry mid-frame: poison the slot and skip the FCS.
                        state_d    = ST_ABORT;
                        tx_er_d    = 1'b1;
                        underrun_d = 1'b1;
                    end
                end else begin
                    // The final accepted byte is on the wire now.
                    tail_step = 1'b1;
                end
            end
`ifdef ETH_TX_FRAMER_PAD_EN
            ST_PAD: begin
                tail_step = 1'b1;
            end
`endif
            ST_FCS: begin
                if (cnt_q == 8'd4) begin
                    state_d = ST_IFG;
                    cnt_d   = 8'd1;
                end else begin
                    tx_en_d = 1'b1;
                    txd_d   = ~crc_q[{cnt_q[1:0], 3'b000} +: 8];
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            ST_ABORT: begin
                state_d = ST_IFG;
                cnt_d   = 8'd1;
            end
            ST_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    // A frame already waiting starts its preamble right away.
                    if (s_valid) begin
                        state_d = ST_PRE;
                        cnt_d   = 8'd1;
                        txd_d   = 8'h55;
                        tx_en_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // After the payload: pad up to the minimum length if enabled, else start the FCS.
        if (tail_step) begin
            tx_en_d = 1'b1;
`ifdef ETH_TX_FRAMER_PAD_EN
            if (byte_count_q < 16'(MIN_FRAME_LEN)) begin
                state_d      = ST_PAD;
                txd_d        = 8'h00;
                crc_d        = crc_next;
                byte_count_d = byte_count_inc;
            end else
`endif
            begin
                state_d = ST_FCS;
                cnt_d   = 8'd1;
                txd_d   = ~crc_q[7:0];
            end
        end
    end

    // State, counters, CRC and all registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            crc_q        <= CRC_INIT;
            byte_count_q <= 16'd0;
            txd_q        <= 8'h00;
            tx_en_q      <= 1'b0;
            tx_er_q      <= 1'b0;
            s_ready_q    <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            crc_q        <= crc_d;
            byte_count_q <= byte_count_d;
            txd_q        <= txd_d;
            tx_en_q      <= tx_en_d;
            tx_er_q      <= tx_er_d;
            s_ready_q    <= s_ready_d;
            underrun_q   <= underrun_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign gmii_txd   = txd_q;
    assign gmii_tx_en = tx_en_q;
    assign gmii_tx_er = tx_er_q;
    assign underrun   = underrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer
// Drives directed and random frames into eth_tx_framer and checks the GMII
// byte stream against a frame-level reference model (preamble, SFD, payload,
// optional padding, CRC-32 FCS), plus handshake, underrun and IFG timing.
// Honours ETH_TX_FRAMER_PAD_EN the same way the design does.
module tb_eth_tx_framer;

    localparam int PRE_LEN = 7;
    localparam int MIN_LEN = 60;
    localparam int IFG_LEN = 12;

    typedef logic [7:0] bq_t[$];

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       underrun;
    logic       busy;

    int checks = 0;
    int passed = 0;

    bq_t got;
    int  ready_cycles, er_cycles, er_pos, urun_cycles, lead_zero;

    eth_tx_framer #(
        .PREAMBLE_LEN (PRE_LEN),
        .MIN_FRAME_LEN(MIN_LEN),
        .IFG_CYCLES   (IFG_LEN)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .gmii_txd  (gmii_txd),
        .gmii_tx_en(gmii_tx_en),
        .gmii_tx_er(gmii_tx_er),
        .underrun  (underrun),
        .busy      (busy)
    );

    always #4 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Reference CRC-32 (IEEE 802.3): bit-serial, LSB of each byte first, FCS is complemented.
    function automatic logic [31:0] fcs_of(input bq_t body);
        logic [31:0] crc;
        logic        fb;
        crc = 32'hFFFFFFFF;
        foreach (body[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb  = crc[0] ^ body[i][b];
                crc = (crc >> 1) ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        end
        return ~crc;
    endfunction

    // Expected wire bytes (tx_en high) for one frame; abort_at < 0 means no underrun.
    function automatic bq_t model_wire(input bq_t pl, input int abort_at);
        bq_t         w;
        bq_t         body;
        logic [31:0] fcs;
        for (int i = 0; i < PRE_LEN; i++) w.push_back(8'h55);
        w.push_back(8'hD5);
        if (abort_at >= 0) begin
            for (int i = 0; i < abort_at; i++) w.push_back(pl[i]);
            w.push_back(8'h00);
            return w;
        end
        body = pl;
`ifdef ETH_TX_FRAMER_PAD_EN
        while (body.size() < MIN_LEN) body.push_back(8'h00);
`endif
        fcs = fcs_of(body);
        foreach (body[i]) w.push_back(body[i]);
        for (int k = 0; k < 4; k++) w.push_back(fcs[8*k +: 8]);
        return w;
    endfunction

    function automatic bq_t rand_payload(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Present one frame and record the wire until tx_en falls after the burst.
    task automatic run_frame(input bq_t pl, input int abort_at);
        int idx;
        int n;
        int budget;
        bit started;
        bit done;
        bit aborted;
        bit hs;
        idx = 0; n = pl.size(); budget = 0;
        started = 0; done = 0; aborted = 0;
        got.delete();
        ready_cycles = 0; er_cycles = 0; er_pos = -1; urun_cycles = 0;
        lead_zero = gmii_tx_en ? 0 : 1;
        s_valid = 1'b1; s_data = pl[0]; s_last = (n == 1);
        while (!done && budget < 400) begin
            if (!aborted && idx == abort_at && s_ready) begin
                s_valid = 1'b0; s_last = 1'b0; aborted = 1;
            end
            hs = s_valid && s_ready;
            @(posedge clock); #1;
            budget++;
            if (hs) begin
                idx++;
                if (idx < n) begin
                    s_data = pl[idx]; s_last = (idx == n - 1);
                end else begin
                    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
                end
            end
            if (gmii_tx_en) begin
                started = 1;
                got.push_back(gmii_txd);
                if (gmii_tx_er) begin
                    er_cycles++;
                    er_pos = got.size() - 1;
                end
            end else if (started) begin
                done = 1;
            end else begin
                lead_zero++;
            end
            if (s_ready) ready_cycles++;
            if (underrun) urun_cycles++;
        end
        chk("frame_done_in_budget", 32'(done), 32'd1);
    endtask

    // Count busy cycles (current one included) until the framer is idle again.
    task automatic wait_idle(input string tag, input int exp_cycles);
        int cnt;
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            @(posedge clock); #1;
        end
        chk({tag, "_ifg_busy"}, 32'(cnt), 32'(exp_cycles));
    endtask

    task automatic compare_wire(input string tag, input bq_t exp);
        chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
        $display("frame %s: %0d wire bytes, %0d expected", tag, got.size(), exp.size());
    endtask

    initial begin
        bq_t pl;
        bq_t pl2;
        bq_t exp;
        bq_t got_a;
        bq_t exp_b;
        int  pre_seen;
        int  n;

        // Reset state
        @(posedge clock); @(posedge clock); #1;
        chk("rst_txd", 32'(gmii_txd), 32'd0);
        chk("rst_tx_en", 32'(gmii_tx_en), 32'd0);
        chk("rst_tx_er", 32'(gmii_tx_er), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // "123456789": known check value 0xCBF43926 when unpadded
        pl = {};
        for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
        run_frame(pl, -1);
        exp = model_wire(pl, -1);
        compare_wire("ascii9", exp);
`ifdef ETH_TX_FRAMER_PAD_EN
        chk("ascii9_tx_en_cycles", 32'(got.size()), 32'd72);
`else
        if (got.size() == 21) begin
            chk("ascii9_fcs0", 32'(got[17]), 32'h26);
            chk("ascii9_fcs1", 32'(got[18]), 32'h39);
            chk("ascii9_fcs2", 32'(got[19]), 32'hF4);
            chk("ascii9_fcs3", 32'(got[20]), 32'hCB);
        end else begin
            chk("ascii9_fcs_len", 32'(got.size()), 32'd21);
        end
`endif
        chk("ascii9_ready_cycles", 32'(ready_cycles), 32'd9);
        chk("ascii9_tx_er", 32'(er_cycles), 32'd0);
        chk("ascii9_underrun", 32'(urun_cycles), 32'd0);
        wait_idle("ascii9", IFG_LEN);

        // Single-byte frame with s_last on the first byte
        pl = rand_payload(1);
        run_frame(pl, -1);
        compare_wire("one_byte", model_wire(pl, -1));
        chk("one_byte_ready_cycles", 32'(ready_cycles), 32'd1);
        wait_idle("one_byte", IFG_LEN);

        // Underrun at byte 20 of a 64-byte frame
        pl = rand_payload(64);
        run_frame(pl, 20);
        compare_wire("underrun", model_wire(pl, 20));
        chk("underrun_er_cycles", 32'(er_cycles), 32'd1);
        chk("underrun_er_pos", 32'(er_pos), 32'(PRE_LEN + 1 + 20));
        chk("underrun_pulses", 32'(urun_cycles), 32'd1);
        chk("underrun_ready_cycles", 32'(ready_cycles), 32'd21);
        wait_idle("underrun", IFG_LEN);

        // Two back-to-back 60-byte frames, second one offered during the IFG
        pl = rand_payload(60);
        pl2 = rand_payload(60);
        run_frame(pl, -1);
        got_a = got;
        run_frame(pl2, -1);
        exp_b = got;
        got = got_a;
        compare_wire("b2b_a", model_wire(pl, -1));
        got = exp_b;
        compare_wire("b2b_b", model_wire(pl2, -1));
        chk("b2b_gap", 32'(lead_zero), 32'(IFG_LEN));
        wait_idle("b2b", IFG_LEN);

        // Reset pulsed on the third preamble byte, then a clean frame
        pl = rand_payload(15);
        s_valid = 1'b1; s_data = pl[0]; s_last = 1'b0;
        pre_seen = 0;
        for (int c = 0; c < 20 && pre_seen < 3; c++) begin
            @(posedge clock); #1;
            if (gmii_tx_en) pre_seen++;
        end
        chk("rst_mid_pre_seen", 32'(pre_seen), 32'd3);
        reset = 1'b1;
        #1;
        chk("rst_mid_tx_en", 32'(gmii_tx_en), 32'd0);
        chk("rst_mid_txd", 32'(gmii_txd), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_s_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        run_frame(pl, -1);
        compare_wire("after_reset", model_wire(pl, -1));
        wait_idle("after_reset", IFG_LEN);

        // Random frames with random idle spacing
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 90);
            pl = rand_payload(n);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clock); #1;
            end
            run_frame(pl, -1);
            compare_wire($sformatf("rand%0d", f), model_wire(pl, -1));
            chk($sformatf("rand%0d_ready_cycles", f), 32'(ready_cycles), 32'(n));
            wait_idle($sformatf("rand%0d", f), IFG_LEN);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
